// File: rtl/pll_lock_sequencer.sv
// PLL power-up / relock sequencer for the Gowin rPLL.
// Pulses the PLL reset, waits for a qualified lock (with timeout and bounded
// retries), then releases the downstream synchronous reset. Lock loss in RUN
// restarts the sequence; exhausted retries latch FAULT until reset/retry_req.
module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT = 100000,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lock,
    input  logic       retry_req,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       locked_ok,
    output logic       fault,
    output logic [7:0] retry_count
);

    localparam int unsigned RstW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned StW  = $clog2(LOCK_STABLE + 1);
    localparam int unsigned AtW  = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StStable,
        StRun,
        StFault
    } state_t;

    state_t          state_q, state_d;
    logic [RstW-1:0] t_rst_q, t_rst_d;
    logic [ToW-1:0]  t_to_q, t_to_d;
    logic [StW-1:0]  t_st_q, t_st_d;
    logic [AtW-1:0]  attempts_q, attempts_d;
    logic [7:0]      rc_q, rc_d;
    logic            sync1_q, lock_s;
    logic            timeout;
    logic            bump;

    // Two-flop synchronizer for the asynchronous PLL lock output.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync1_q <= lock;
            lock_s  <= sync1_q;
        end
    end

    // >= rather than ==: entering STABLE on the last WAIT_LOCK cycle pushes
    // t_to one past the limit, and that must still count as a timeout.
    assign timeout = (t_to_q >= ToW'(LOCK_TIMEOUT - 1));

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        t_rst_d    = t_rst_q;
        t_to_d     = t_to_q;
        t_st_d     = t_st_q;
        attempts_d = attempts_q;
        bump       = 1'b0;

        unique case (state_q)
            StPllRst: begin
                if (t_rst_q == RstW'(RESET_CYCLES - 1)) begin
                    state_d = StWaitLock;
                    t_rst_d = '0;
                end else begin
                    t_rst_d = t_rst_q + 1'b1;
                end
            end
            StWaitLock: begin
                t_to_d = t_to_q + 1'b1;
                if (lock_s) begin
                    state_d = StStable;
                    t_st_d  = '0;
                end else if (timeout) begin
                    if (attempts_q == AtW'(MAX_RETRY)) begin
                        state_d = StFault;
                    end else begin
                        state_d    = StPllRst;
                        attempts_d = attempts_q + 1'b1;
                        bump       = 1'b1;
                    end
                end
            end
            StStable: begin
                t_to_d = t_to_q + 1'b1;
                // Timeout wins over both a lock drop and qualification.
                if (timeout) begin
                    if (attempts_q == AtW'(MAX_RETRY)) begin
                        state_d = StFault;
                    end else begin
                        state_d    = StPllRst;
                        attempts_d = attempts_q + 1'b1;
                        bump       = 1'b1;
                    end
                end else if (!lock_s) begin
                    state_d = StWaitLock;
                end else if (t_st_q == StW'(LOCK_STABLE - 1)) begin
                    state_d = StRun;
                end else begin
                    t_st_d = t_st_q + 1'b1;
                end
            end
            StRun: begin
                attempts_d = '0;
                // Lock loss and retry_req together still yield one restart.
                if (!lock_s || retry_req) begin
                    state_d = StPllRst;
                    bump    = 1'b1;
                end
            end
            StFault: begin
                if (retry_req) begin
                    state_d    = StPllRst;
                    attempts_d = '0;
                    bump       = 1'b1;
                end
            end
            default: begin
                state_d = StPllRst;
            end
        endcase

        // Every entry into PLLRST starts a fresh pulse and timeout window.
        if (state_d == StPllRst && state_q != StPllRst) begin
            t_rst_d = '0;
            t_to_d  = '0;
        end

        rc_d = (bump && rc_q != 8'hFF) ? rc_q + 8'd1 : rc_q;
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StPllRst;
            t_rst_q    <= '0;
            t_to_q     <= '0;
            t_st_q     <= '0;
            attempts_q <= '0;
            rc_q       <= '0;
        end else begin
            state_q    <= state_d;
            t_rst_q    <= t_rst_d;
            t_to_q     <= t_to_d;
            t_st_q     <= t_st_d;
            attempts_q <= attempts_d;
            rc_q       <= rc_d;
        end
    end

    // Registered outputs, decoded from the current state one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            locked_ok   <= 1'b0;
            fault       <= 1'b0;
            retry_count <= 8'd0;
        end else begin
            pll_reset   <= (state_q == StPllRst) || (state_q == StFault);
            sys_reset   <= (state_q != StRun);
            locked_ok   <= (state_q == StRun);
            fault       <= (state_q == StFault);
            retry_count <= rc_q;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer. Expected timings are derived
// arithmetically from the sequencing rules; retry_count is tracked by
// counting the restarts each scenario is expected to cause.
module tb_pll_lock_sequencer;

    localparam int unsigned RC = 4;
    localparam int unsigned LT = 64;
    localparam int unsigned LS = 8;
    localparam int unsigned MR = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lock = 1'b0;
    logic       retry_req = 1'b0;
    logic       pll_reset;
    logic       sys_reset;
    logic       locked_ok;
    logic       fault;
    logic [7:0] retry_count;

    int errors = 0;
    int checks = 0;
    int model_rc = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES(RC),
        .LOCK_TIMEOUT(LT),
        .LOCK_STABLE (LS),
        .MAX_RETRY   (MR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lock       (lock),
        .retry_req  (retry_req),
        .pll_reset  (pll_reset),
        .sys_reset  (sys_reset),
        .locked_ok  (locked_ok),
        .fault      (fault),
        .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        retry_req = 1'b0;
        step();
        step();
        reset    = 1'b0;
        model_rc = 0;
    endtask

    // Wait (bounded) until pll_reset is low, counting high samples.
    task automatic wait_pll_release(output int highs);
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (pll_reset === 1'b1) highs++;
            else break;
        end
    endtask

    // Bounded wait for locked_ok.
    task automatic wait_run();
        for (int i = 0; i < 300 && locked_ok !== 1'b1; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lock  = 1'($urandom_range(0, 1));
        step();
        step();
        checks++;
        if (pll_reset !== 1'b1) begin
            errors++; $display("FAIL reset_pll_reset got=%b want=1", pll_reset);
        end
        checks++;
        if (sys_reset !== 1'b1) begin
            errors++; $display("FAIL reset_sys_reset got=%b want=1", sys_reset);
        end
        checks++;
        if (locked_ok !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got locked_ok=%b fault=%b want 0 0", locked_ok, fault);
        end
        checks++;
        if (retry_count !== 8'd0) begin
            errors++; $display("FAIL reset_retry_count got=%0d want=0", retry_count);
        end
        lock = 1'b0;
    endtask

    task automatic test_clean_lock();
        int highs;
        int n;
        apply_reset();
        lock = 1'b0;
        wait_pll_release(highs);
        checks++;
        if (highs != RC) begin
            errors++; $display("FAIL clean_pll_width got=%0d want=%0d", highs, RC);
        end
        repeat ($urandom_range(5, 15)) step();
        lock = 1'b1;
        step();  // first edge sampling lock=1
        n = 0;
        while (sys_reset === 1'b1 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n != LS + 3) begin
            errors++; $display("FAIL clean_sys_reset_latency got=%0d want=%0d", n, LS + 3);
        end
        checks++;
        if (locked_ok !== 1'b1 || fault !== 1'b0 || pll_reset !== 1'b0) begin
            errors++;
            $display("FAIL clean_run_outputs got locked_ok=%b fault=%b pll_reset=%b want 1 0 0",
                     locked_ok, fault, pll_reset);
        end
        checks++;
        if (retry_count !== 8'(model_rc)) begin
            errors++; $display("FAIL clean_retry_count got=%0d want=%0d", retry_count, model_rc);
        end
    endtask

    task automatic test_loss_in_run();
        int n;
        int highs;
        lock = 1'b0;
        step();  // edge sampling lock=0
        lock = 1'b1;
        n = 0;
        while (sys_reset === 1'b0 && n < 20) begin
            step();
            n++;
        end
        model_rc++;
        checks++;
        if (n != 3 || pll_reset !== 1'b1) begin
            errors++;
            $display("FAIL loss_latency got=%0d pll_reset=%b want=3 pll_reset=1", n, pll_reset);
        end
        checks++;
        if (retry_count !== 8'(model_rc)) begin
            errors++; $display("FAIL loss_retry_count got=%0d want=%0d", retry_count, model_rc);
        end
        wait_pll_release(highs);
        checks++;
        if (highs + 1 != RC) begin
            errors++; $display("FAIL loss_pll_width got=%0d want=%0d", highs + 1, RC);
        end
        wait_run();
        checks++;
        if (locked_ok !== 1'b1) begin
            errors++; $display("FAIL loss_relock got=%b want=1", locked_ok);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        // Lock loss and retry_req reach the RUN decision on the same edge.
        lock = 1'b0;
        step();
        lock = 1'b1;
        step();
        retry_req = 1'b1;
        step();
        retry_req = 1'b0;
        model_rc++;
        for (int i = 0; i < 10 && sys_reset !== 1'b1; i++) step();
        checks++;
        if (retry_count !== 8'(model_rc)) begin
            errors++; $display("FAIL coincident_retry_count got=%0d want=%0d", retry_count, model_rc);
        end
        wait_run();
        // retry_req alone in RUN.
        repeat ($urandom_range(1, 10)) step();
        retry_req = 1'b1;
        step();
        retry_req = 1'b0;
        model_rc++;
        n = 0;
        while (sys_reset === 1'b0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != 1 || retry_count !== 8'(model_rc)) begin
            errors++;
            $display("FAIL run_retry_req got latency=%0d count=%0d want latency=1 count=%0d",
                     n, retry_count, model_rc);
        end
        wait_run();
        checks++;
        if (locked_ok !== 1'b1) begin
            errors++; $display("FAIL run_retry_relock got=%b want=1", locked_ok);
        end
    endtask

    task automatic test_chatter();
        int n;
        int first_n;
        int highs;
        int phase;
        bit seen_run;
        bit pll_at_first;
        // Phase keeps the synchronized lock low at the timeout edge.
        phase    = $urandom_range(5, 9);
        seen_run = 1'b0;
        first_n  = -1;
        apply_reset();
        n    = 0;
        lock = 1'(((n + phase) / 5) % 2);
        while (first_n < 0 && n < 300) begin
            step();
            n++;
            lock = 1'(((n + phase) / 5) % 2);
            if (locked_ok === 1'b1 || sys_reset !== 1'b1) seen_run = 1'b1;
            if (retry_count == 8'd1) begin
                first_n      = n;
                pll_at_first = pll_reset;
            end
        end
        model_rc++;
        checks++;
        if (first_n != RC + LT + 1 || pll_at_first !== 1'b1) begin
            errors++;
            $display("FAIL chatter_timeout_cycle got=%0d pll_reset=%b want=%0d pll_reset=1",
                     first_n, pll_at_first, RC + LT + 1);
        end
        highs = 1;
        for (int i = 0; i < 50; i++) begin
            step();
            n++;
            lock = 1'(((n + phase) / 5) % 2);
            if (locked_ok === 1'b1) seen_run = 1'b1;
            if (pll_reset === 1'b1) highs++;
            else break;
        end
        checks++;
        if (highs != RC) begin
            errors++; $display("FAIL chatter_pll_width got=%0d want=%0d", highs, RC);
        end
        lock = 1'b0;
        repeat (10) step();
        checks++;
        if (seen_run || retry_count !== 8'(model_rc)) begin
            errors++;
            $display("FAIL chatter_no_run got seen_run=%b count=%0d want 0 %0d",
                     seen_run, retry_count, model_rc);
        end
    endtask

    task automatic test_never_lock();
        int n;
        bit held;
        apply_reset();
        lock = 1'b0;
        n    = 0;
        while (fault !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        model_rc += MR;
        checks++;
        if (n != (1 + MR) * (RC + LT) + 1) begin
            errors++;
            $display("FAIL never_fault_cycle got=%0d want=%0d", n, (1 + MR) * (RC + LT) + 1);
        end
        checks++;
        if (retry_count !== 8'(model_rc)) begin
            errors++; $display("FAIL never_retry_count got=%0d want=%0d", retry_count, model_rc);
        end
        held = 1'b1;
        repeat ($urandom_range(20, 60)) begin
            step();
            if (fault !== 1'b1 || pll_reset !== 1'b1 || sys_reset !== 1'b1 || locked_ok !== 1'b0)
                held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL never_fault_held got fault=%b pll=%b sys=%b want 1 1 1",
                     fault, pll_reset, sys_reset);
        end
    endtask

    task automatic test_fault_recovery();
        int highs;
        int n;
        retry_req = 1'b1;
        step();
        retry_req = 1'b0;
        step();
        model_rc++;
        checks++;
        if (fault !== 1'b0 || retry_count !== 8'(model_rc)) begin
            errors++;
            $display("FAIL recover_fault_clear got fault=%b count=%0d want 0 %0d",
                     fault, retry_count, model_rc);
        end
        wait_pll_release(highs);
        // retry_req in WAIT_LOCK must be ignored.
        retry_req = 1'b1;
        step();
        retry_req = 1'b0;
        repeat (3) step();
        checks++;
        if (pll_reset !== 1'b0 || retry_count !== 8'(model_rc)) begin
            errors++;
            $display("FAIL recover_ignore_retry got pll=%b count=%0d want 0 %0d",
                     pll_reset, retry_count, model_rc);
        end
        lock = 1'b1;
        step();
        n = 0;
        while (sys_reset === 1'b1 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n != LS + 3 || locked_ok !== 1'b1) begin
            errors++;
            $display("FAIL recover_run got latency=%0d locked_ok=%b want=%0d 1", n, locked_ok, LS + 3);
        end
    endtask

    task automatic test_reset_in_fault();
        apply_reset();
        lock = 1'b0;
        for (int i = 0; i < 1000 && fault !== 1'b1; i++) step();
        reset = 1'b1;
        step();
        checks++;
        if (fault !== 1'b0 || pll_reset !== 1'b1 || sys_reset !== 1'b1 || retry_count !== 8'd0) begin
            errors++;
            $display("FAIL fault_reset got fault=%b pll=%b sys=%b count=%0d want 0 1 1 0",
                     fault, pll_reset, sys_reset, retry_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_stable();
        int highs;
        apply_reset();
        lock = 1'b1;
        wait_run();
        // Restart so retry_count is nonzero, with lock held low through PLLRST.
        lock      = 1'b0;
        retry_req = 1'b1;
        step();
        retry_req = 1'b0;
        for (int i = 0; i < 20 && pll_reset !== 1'b1; i++) step();
        wait_pll_release(highs);
        lock = 1'b1;
        step();  // edge sampling lock=1
        repeat (7) step();  // t_st now 5
        checks++;
        if (sys_reset !== 1'b1 || pll_reset !== 1'b0 || retry_count !== 8'd1) begin
            errors++;
            $display("FAIL stable_pre_reset got sys=%b pll=%b count=%0d want 1 0 1",
                     sys_reset, pll_reset, retry_count);
        end
        reset = 1'b1;
        step();
        checks++;
        if (pll_reset !== 1'b1 || sys_reset !== 1'b1 || locked_ok !== 1'b0 || fault !== 1'b0 ||
            retry_count !== 8'd0) begin
            errors++;
            $display("FAIL stable_reset got pll=%b sys=%b ok=%b fault=%b count=%0d want 1 1 0 0 0",
                     pll_reset, sys_reset, locked_ok, fault, retry_count);
        end
        reset = 1'b0;
        model_rc = 0;
        wait_pll_release(highs);
        checks++;
        if (highs != RC) begin
            errors++; $display("FAIL stable_restart_width got=%0d want=%0d", highs, RC);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_loss_in_run();
        test_back_to_back();
        test_chatter();
        test_never_lock();
        test_fault_recovery();
        test_reset_in_fault();
        test_reset_mid_stable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
